// File: rtl/mem_port_arbiter_if.sv
// Requester-side bundle for mem_port_arbiter: one instance per port.
// The requester drives the access, the arbiter drives grant/completion and the shared read data.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of a fixed-latency synchronous memory (CPU on p0, loader on p1).
// Define ARB_CPU_PRIO_EN for fixed CPU priority on ties; default is round-robin.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   p0,
  mem_port_arbiter_if.slave   p1,
  output logic                o_busy,
  output logic                o_mem_en,
  output logic                o_mem_we,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [DATA_W-1:0]   o_mem_wdata,
  input  logic [DATA_W-1:0]   i_mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [3:0] LAT_CNT = 4'(MEM_LAT);

  state_t            r_state;
  state_t            w_next;
  logic              r_port;
  logic              r_we;
  logic              r_last_winner;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic [3:0]        r_cnt;

  logic              w_any_req;
  logic              w_win;
  logic              w_last_wait;

  // Winner id: 0 = CPU, 1 = loader. Only meaningful while in IDLE.
  always_comb begin
    w_any_req = p0.req | p1.req;
    if (p0.req && p1.req) begin
`ifdef ARB_CPU_PRIO_EN
      w_win = 1'b0;
`else
      w_win = ~r_last_winner;
`endif
    end else begin
      w_win = p1.req & ~p0.req;
    end
  end

  assign w_last_wait = (r_cnt <= 4'd1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    w_next    = r_state;
    o_mem_en  = 1'b0;
    o_mem_we  = 1'b0;
    p0.gnt    = 1'b0;
    p1.gnt    = 1'b0;
    p0.rvalid = 1'b0;
    p1.rvalid = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_any_req) w_next = ISSUE;
      end
      ISSUE: begin
        o_mem_en = 1'b1;
        o_mem_we = r_we;
        p0.gnt   = ~r_port;
        p1.gnt   = r_port;
        w_next   = WAIT;
      end
      WAIT: begin
        if (w_last_wait) w_next = RESP;
      end
      RESP: begin
        p0.rvalid = ~r_port;
        p1.rvalid = r_port;
        w_next    = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Access capture, latency counter and response data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_port        <= 1'b0;
      r_we          <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_rdata       <= '0;
      r_cnt         <= 4'd0;
      r_last_winner <= 1'b1;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_port        <= w_win;
            r_last_winner <= w_win;
            r_we          <= w_win ? p1.we    : p0.we;
            r_addr        <= w_win ? p1.addr  : p0.addr;
            r_wdata       <= w_win ? p1.wdata : p0.wdata;
          end
        end
        ISSUE: begin
          r_cnt <= LAT_CNT;
        end
        WAIT: begin
          if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
          if (w_last_wait) r_rdata <= r_we ? '0 : i_mem_rdata;
        end
        default: ;
      endcase
    end
  end

  // The memory bus reflects the captured access; strobes gate it.
  assign o_busy      = (r_state != IDLE);
  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;
  assign p0.rdata    = r_rdata;
  assign p1.rdata    = r_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: schedule-based reference model plus
// a behavioural fixed-latency memory; honours ARB_CPU_PRIO_EN when defined.
module tb_mem_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int LAT  = 1;
  localparam int P    = LAT + 3;
  localparam int LAT3 = 3;
`ifdef ARB_CPU_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- DUT with MEM_LAT = 1 ----------------
  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) if0 ();
  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) if1 ();
  logic          busy1, m1_en, m1_we;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) u_dut (
    .clk(clk), .rst(rst), .p0(if0), .p1(if1),
    .o_busy(busy1), .o_mem_en(m1_en), .o_mem_we(m1_we),
    .o_mem_addr(m1_addr), .o_mem_wdata(m1_wdata), .i_mem_rdata(m1_rdata)
  );

  // ---------------- DUT with MEM_LAT = 3 ----------------
  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) q0 ();
  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) q1 ();
  logic          busy3, m3_en, m3_we;
  logic [AW-1:0] m3_addr;
  logic [DW-1:0] m3_wdata, m3_rdata;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT3)) u_dut3 (
    .clk(clk), .rst(rst), .p0(q0), .p1(q1),
    .o_busy(busy3), .o_mem_en(m3_en), .o_mem_we(m3_we),
    .o_mem_addr(m3_addr), .o_mem_wdata(m3_wdata), .i_mem_rdata(m3_rdata)
  );

  // ---------------- behavioural memories ----------------
  function automatic logic [31:0] init_word(input logic [7:0] idx);
    case (idx)
      8'h10:   return 32'hDEADBEEF;
      8'h08:   return 32'hCAFEF00D;
      default: return {24'h5A5A5A, idx};
    endcase
  endfunction

  bit          mem_load = 1'b1;
  logic [31:0] mem1 [256];
  logic [31:0] mem3 [256];
  logic [31:0] rd1;
  logic [31:0] rd3 [LAT3];

  // Read data is only valid exactly MEM_LAT cycles after the strobe; poison otherwise.
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 256; i++) begin
        mem1[i] <= init_word(8'(i));
        mem3[i] <= init_word(8'(i));
      end
      rd1 <= 32'hBAD0BAD0;
      for (int i = 0; i < LAT3; i++) rd3[i] <= 32'hBAD0BAD0;
    end else begin
      if (m1_en && m1_we) mem1[m1_addr[7:0]] <= m1_wdata;
      rd1 <= (m1_en && !m1_we) ? mem1[m1_addr[7:0]] : 32'hBAD0BAD0;
      if (m3_en && m3_we) mem3[m3_addr[7:0]] <= m3_wdata;
      rd3[0] <= (m3_en && !m3_we) ? mem3[m3_addr[7:0]] : 32'hBAD0BAD0;
      for (int i = 1; i < LAT3; i++) rd3[i] <= rd3[i-1];
    end
  end
  assign m1_rdata = rd1;
  assign m3_rdata = rd3[LAT3-1];

  // ---------------- reference model state ----------------
  logic [31:0] shadow [256];
  int          last_win;
  logic [31:0] hold_rdata;

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    if0.req = 1'b0; if1.req = 1'b0; q0.req = 1'b0; q1.req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    last_win   = 1;
    hold_rdata = '0;
  endtask

  // One arbitration round: r0/r1 request together in cycle 0; the model
  // derives service order, then each access occupies P cycles.
  task automatic run_access(input string tag,
                            input bit r0, input bit we0v, input logic [31:0] a0, input logic [31:0] d0,
                            input bit r1, input bit we1v, input logic [31:0] a1, input logic [31:0] d1);
    int          n, first, k, ph, last_c;
    int          port [2];
    bit          we [2];
    logic [31:0] ad [2], wd [2], rd [2];
    logic [6:0]  obs, exp_v;

    n = 0;
    if (r0 && r1) begin
      first   = PRIO ? 0 : 1 - last_win;
      port[0] = first;
      port[1] = 1 - first;
      n = 2;
    end else if (r0) begin
      port[0] = 0; n = 1;
    end else if (r1) begin
      port[0] = 1; n = 1;
    end
    for (int j = 0; j < n; j++) begin
      if (port[j] == 0) begin we[j] = we0v; ad[j] = a0; wd[j] = d0; end
      else              begin we[j] = we1v; ad[j] = a1; wd[j] = d1; end
      rd[j] = we[j] ? 32'h0 : shadow[ad[j][7:0]];
      if (we[j]) shadow[ad[j][7:0]] = wd[j];
      last_win = port[j];
    end

    @(negedge clk);
    if0.req = r0; if0.we = we0v; if0.addr = a0; if0.wdata = d0;
    if1.req = r1; if1.we = we1v; if1.addr = a1; if1.wdata = d1;

    last_c = (n == 0) ? 1 : n * P;
    for (int c = 0; c <= last_c; c++) begin
      if (c > 0) @(negedge clk);
      k  = c / P;
      ph = c % P;
      exp_v = '0;
      if (k < n) begin
        if (ph != 0) exp_v[2] = 1'b1;
        if (ph == 1) begin
          exp_v[port[k] == 0 ? 6 : 5] = 1'b1;
          exp_v[1] = 1'b1;
          exp_v[0] = we[k];
        end
        if (ph == P - 1) begin
          exp_v[port[k] == 0 ? 4 : 3] = 1'b1;
          hold_rdata = rd[k];
        end
      end
      obs = {if0.gnt, if1.gnt, if0.rvalid, if1.rvalid, busy1, m1_en, m1_we};
      n_checks++;
      if (obs !== exp_v) begin
        n_errors++;
        $display("FAIL %s flags c%0d {g0,g1,v0,v1,busy,en,we}: got %b want %b", tag, c, obs, exp_v);
      end
      n_checks++;
      if ({if0.rdata, if1.rdata} !== {hold_rdata, hold_rdata}) begin
        n_errors++;
        $display("FAIL %s rdata c%0d: got %h/%h want %h", tag, c, if0.rdata, if1.rdata, hold_rdata);
      end
      if (k < n && ph == 1) begin
        n_checks++;
        if (m1_addr !== ad[k] || (we[k] && m1_wdata !== wd[k])) begin
          n_errors++;
          $display("FAIL %s mem_bus c%0d: got addr %h wdata %h want addr %h wdata %h",
                   tag, c, m1_addr, m1_wdata, ad[k], wd[k]);
        end
      end
      if (if0.gnt === 1'b1) if0.req = 1'b0;
      if (if1.gnt === 1'b1) if1.req = 1'b0;
    end
    if0.req = 1'b0;
    if1.req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({if0.gnt, if1.gnt, if0.rvalid, if1.rvalid, busy1, m1_en, m1_we} !== 7'b0 ||
        {q0.gnt, q0.rvalid, busy3, m3_en} !== 4'b0) begin
      n_errors++;
      $display("FAIL reset_flags: got %b/%b want all zero",
               {if0.gnt, if1.gnt, if0.rvalid, if1.rvalid, busy1, m1_en, m1_we},
               {q0.gnt, q0.rvalid, busy3, m3_en});
    end
    n_checks++;
    if (if0.rdata !== 32'h0 || m1_addr !== 32'h0 || m1_wdata !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_bus: got rdata %h addr %h wdata %h want 0", if0.rdata, m1_addr, m1_wdata);
    end
    mem_load = 1'b0;
    for (int i = 0; i < 256; i++) shadow[i] = init_word(8'(i));
    rst        = 1'b0;
    last_win   = 1;
    hold_rdata = '0;
  endtask

  task automatic test_single_read();
    run_access("read0", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    n_checks++;
    if (if0.rdata !== 32'hDEADBEEF) begin
      n_errors++;
      $display("FAIL read0_value: got %h want deadbeef", if0.rdata);
    end
  endtask

  task automatic test_write_readback();
    run_access("write1", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h20, 32'h12345678);
    run_access("readback0", 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    n_checks++;
    if (if0.rdata !== 32'h12345678) begin
      n_errors++;
      $display("FAIL readback_value: got %h want 12345678", if0.rdata);
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    run_access("tie_a", 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h08, 32'h0);
    run_access("tie_b", 1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0);
  endtask

  task automatic test_latency3();
    logic [3:0] obs, exp_v;
    @(negedge clk);
    q0.req = 1'b1; q0.we = 1'b0; q0.addr = 32'h08; q0.wdata = 32'h0;
    for (int c = 0; c <= 6; c++) begin
      if (c > 0) @(negedge clk);
      exp_v = {c == 1, c == 5, c == 1, c >= 1 && c <= 5};
      obs   = {q0.gnt, q0.rvalid, m3_en, busy3};
      n_checks++;
      if (obs !== exp_v) begin
        n_errors++;
        $display("FAIL lat3_flags c%0d {gnt,rvalid,en,busy}: got %b want %b", c, obs, exp_v);
      end
      if (c == 5) begin
        n_checks++;
        if (q0.rdata !== 32'hCAFEF00D) begin
          n_errors++;
          $display("FAIL lat3_rdata: got %h want cafef00d", q0.rdata);
        end
      end
      if (q0.gnt === 1'b1) q0.req = 1'b0;
    end
    q0.req = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    if0.req = 1'b1; if0.we = 1'b0; if0.addr = 32'h10; if0.wdata = 32'h0;
    @(negedge clk);
    if0.req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({if0.gnt, if1.gnt, if0.rvalid, if1.rvalid, busy1, m1_en, m1_we} !== 7'b0 ||
        if0.rdata !== 32'h0 || m1_addr !== 32'h0 || m1_wdata !== 32'h0) begin
      n_errors++;
      $display("FAIL midrst_outputs: got flags %b rdata %h addr %h wdata %h want all zero",
               {if0.gnt, if1.gnt, if0.rvalid, if1.rvalid, busy1, m1_en, m1_we},
               if0.rdata, m1_addr, m1_wdata);
    end
    rst        = 1'b0;
    last_win   = 1;
    hold_rdata = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_checks++;
      if ({if0.rvalid, if1.rvalid, busy1} !== 3'b0) begin
        n_errors++;
        $display("FAIL midrst_quiet c%0d {v0,v1,busy}: got %b want 000", c, {if0.rvalid, if1.rvalid, busy1});
      end
    end
    run_access("post_rst_tie", 1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 1'b1, 32'h30, 32'h0BADF00D);
  endtask

  task automatic test_random();
    logic [1:0]  mask;
    bit          w0, w1;
    logic [31:0] a0, a1, d0, d1;
    for (int t = 0; t < 24; t++) begin
      mask = 2'($urandom_range(0, 3));
      w0 = 1'($urandom_range(0, 1));
      w1 = 1'($urandom_range(0, 1));
      a0 = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
      a1 = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
      d0 = $urandom;
      d1 = $urandom;
      run_access("random", mask[0], w0, a0, d0, mask[1], w1, a1, d1);
    end
  endtask

`ifdef ARB_CPU_PRIO_EN
  task automatic test_cpu_prio();
    int g0, g1;
    bit seen1;
    @(negedge clk);
    if0.req = 1'b1; if0.we = 1'b0; if0.addr = 32'h10; if0.wdata = 32'h0;
    if1.req = 1'b1; if1.we = 1'b0; if1.addr = 32'h20; if1.wdata = 32'h0;
    g0 = 0; g1 = 0;
    for (int c = 0; c < 3 * P; c++) begin
      if (c > 0) @(negedge clk);
      if (if0.gnt === 1'b1) g0++;
      if (if1.gnt === 1'b1) g1++;
    end
    if0.req = 1'b0;
    n_checks++;
    if (g0 != 3 || g1 != 0) begin
      n_errors++;
      $display("FAIL prio_grants: got g0=%0d g1=%0d want g0=3 g1=0", g0, g1);
    end
    seen1 = 1'b0;
    for (int c = 0; c < P + 2 && !seen1; c++) begin
      @(negedge clk);
      if (if1.gnt === 1'b1) seen1 = 1'b1;
    end
    if1.req = 1'b0;
    n_checks++;
    if (!seen1) begin
      n_errors++;
      $display("FAIL prio_port1_after_drop: got no gnt1 want gnt1 within %0d cycles", P + 2);
    end
    repeat (P) @(negedge clk);
    last_win   = 1;
    hold_rdata = shadow[8'h20];
  endtask
`endif

  initial begin
    rst = 1'b1;
    if0.req = 1'b0; if0.we = 1'b0; if0.addr = '0; if0.wdata = '0;
    if1.req = 1'b0; if1.we = 1'b0; if1.addr = '0; if1.wdata = '0;
    q0.req  = 1'b0; q0.we  = 1'b0; q0.addr  = '0; q0.wdata  = '0;
    q1.req  = 1'b0; q1.we  = 1'b0; q1.addr  = '0; q1.wdata  = '0;

    test_reset();
    test_single_read();
    test_write_readback();
    test_round_robin();
    test_latency3();
    test_reset_mid_op();
`ifdef ARB_CPU_PRIO_EN
    test_cpu_prio();
`endif
    test_random();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single unified instruction/data memory of the multi-cycle RISC-V core between two requesters. Port 0 is the CPU datapath (fetch and load/store). Port 1 is a program loader/DMA engine. The block sequences each access through a fixed-latency synchronous memory and returns read data or a write acknowledge to the winning requester. It sits between the CPU top level, the loader and the memory instance.

Parameters:
ADDR_W, 32, address width.
DATA_W, 32, data width.
MEM_LAT, 1, memory read latency in cycles from mem_en to valid mem_rdata; legal range 1..15.

Ports:
clk  in  1  clock; all state changes on rising edge.
rst  in  1  synchronous, active-high reset.
req0  in  1  port 0 (CPU) access request.
we0  in  1  port 0 write enable (1 = write, 0 = read).
addr0  in  ADDR_W  port 0 address.
wdata0  in  DATA_W  port 0 write data.
gnt0  out  1  port 0 grant; one-cycle pulse.
rvalid0  out  1  port 0 completion; one-cycle pulse.
req1, we1, addr1, wdata1, gnt1, rvalid1  as above, for port 1 (loader).
rdata  out  DATA_W  shared response data; qualified by rvalid0 or rvalid1.
busy  out  1  high whenever the FSM is not in IDLE.
mem_en  out  1  memory access strobe.
mem_we  out  1  memory write enable.
mem_addr  out  ADDR_W  memory address.
mem_wdata  out  DATA_W  memory write data.
mem_rdata  in  DATA_W  memory read data; valid MEM_LAT cycles after mem_en.

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset enters IDLE.
- IDLE:
  - reqN is sampled only in this state.
  - If any request is present, the winner's addr, we and wdata are registered, along with its port id, and the FSM goes to ISSUE.
  - With no request, the FSM stays in IDLE.
- ISSUE (1 cycle):
  - mem_en = 1; mem_we, mem_addr and mem_wdata driven from the registered values.
  - gntN = 1 for the winner only.
  - The latency counter loads MEM_LAT; next state is WAIT.
- WAIT (MEM_LAT cycles):
  - The counter decrements each cycle.
  - In the last WAIT cycle, mem_rdata is captured into rdata for reads. For writes, rdata is loaded with 0.
  - Next state is RESP.
- RESP (1 cycle): rvalidN = 1 for the winner; next state is IDLE.
- Timing: request seen in cycle 0 -> gnt and mem_en in cycle 1 -> rvalid in cycle 2+MEM_LAT.
- Throughput: one access per MEM_LAT+3 cycles.
- Arbitration:
  - A single requester always wins.
  - If both request, the winner is the port not equal to last_winner (round-robin).
  - last_winner updates at the transition to ISSUE; its reset value is 1, so port 0 wins the first tie.
- Requester rules:
  - Hold reqN, weN, addrN and wdataN stable until gntN is seen; deassert reqN in the next cycle.
  - A req still high when the FSM returns to IDLE is a new access.
  - Requests arriving during ISSUE, WAIT or RESP are ignored until IDLE; there is no queueing.
- Output defaults:
  - mem_en, mem_we, gnt0/1 and rvalid0/1 are 0 outside the states listed above.
  - rdata holds its value between responses.
- Reset values:
  - All outputs 0: gnt0/1, rvalid0/1, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata.
  - Counter = 0; last_winner = 1.
- Reset mid-operation:
  - Takes effect on the next edge from any state; the FSM returns to IDLE and the in-flight access is abandoned with no rvalid.
  - A write already strobed in ISSUE is not undone.
- Arithmetic: the counter is 4 bits wide, with no wrap. WAIT exits when the count reaches 1.

Optional Feature:
ARB_CPU_PRIO_EN:
- Defined: fixed priority. Port 0 always wins ties; last_winner is still updated but ignored.
- Not defined: round-robin as in Behaviour.
- Single-request behaviour and all timing are identical in both modes.

Test Plan:
1. MEM_LAT=1; memory[0x10]=0xDEADBEEF; req0 read addr 0x10 at cycle 0 -> gnt0 and mem_en with mem_addr=0x10 at cycle 1; rvalid0=1 with rdata=0xDEADBEEF at cycle 3; busy high in cycles 1–3.
2. req1 write addr 0x20, wdata 0x12345678 -> in the gnt1 cycle mem_we=1, mem_wdata=0x12345678; rvalid1 pulses with rdata=0. A following req0 read of 0x20 returns 0x12345678.
3. After reset, hold req0 and req1 high and re-assert each after its rvalid -> grant order is 0,1,0,1; gnt0 and gnt1 are never high together.
4. MEM_LAT=3; read issued at cycle 0 -> mem_en at cycle 1, rvalid at cycle 5; no rvalid in cycles 2–4.
5. rst asserted during WAIT -> at the next edge all outputs are 0 and the FSM is in IDLE; no rvalid appears. A later simultaneous request grants port 0 first.
6. ARB_CPU_PRIO_EN defined; both ports hold req continuously -> port 0 is granted on every arbitration and port 1 is never granted until req0 drops.
